// File: rtl/eth_rx_frame_fifo_pkg.sv
// eth_pkg: shared write-FSM encoding and Ethernet framing constants for the rx frame FIFO
package eth_pkg;
  typedef enum logic [1:0] {WR_IDLE, WR_ACTIVE, WR_DISCARD} wr_state_t;
  localparam int FCS_BYTES = 4;
  localparam int ETH_MIN_PAYLOAD = 60;
  localparam int ETH_MAX_PAYLOAD = 1514;
endpackage

// File: rtl/eth_rx_frame_fifo_if.sv
// eth_rx_frame_fifo_if: 8-bit AXI-stream bundle with master/slave views
interface eth_rx_frame_fifo_if;
  logic [7:0] tdata;
  logic tvalid;
  logic tlast;
  logic tuser;
  logic tready;
  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_rx_frame_ram.sv
// eth_rx_frame_ram: simple dual-port RAM with registered, enable-gated read
module eth_rx_frame_ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int WIDTH = 9
) (
  input  logic clk,
  input  logic we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward rx FIFO; strips FCS, drops bad/runt/oversize/overflow frames.
// Define ETH_RX_FIFO_STATS_EN to add saturating good/bad_fcs/runt/overflow counters.
module eth_rx_frame_fifo
  import eth_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int MIN_LEN = ETH_MIN_PAYLOAD,
  parameter int MAX_LEN = ETH_MAX_PAYLOAD
) (
  input  logic clk,
  input  logic rst,
  eth_rx_frame_fifo_if.slave s_axis,
  eth_rx_frame_fifo_if.master m_axis,
  output logic drop_pulse,
  output logic frame_pulse
`ifdef ETH_RX_FIFO_STATS_EN
  ,
  output logic [31:0] stat_good,
  output logic [31:0] stat_bad_fcs,
  output logic [31:0] stat_runt,
  output logic [31:0] stat_overflow
`endif
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2**ADDR_WIDTH);
  wr_state_t state, state_n;
  logic [PW-1:0] wr_ptr, wr_ptr_n, wr_commit, wr_commit_n, rd_ptr;
  logic [FCS_BYTES-1:0][7:0] dl, dl_n;
  logic [2:0] dl_cnt, dl_cnt_n, cnt_e;
  logic [15:0] len, len_n, len_e;
  logic err, err_n, err_e;
  logic sync, beat, full, dl_full, over, bad, runt;
  logic we, wlast, drop_n, frame_n;
  logic re, v1, load_out, empty;
  logic [8:0] rdata;
  assign s_axis.tready = 1'b1;
  assign m_axis.tuser = 1'b0;
  assign beat = s_axis.tvalid && sync;
  // IDLE presents a fresh per-frame context so the first beat is processed like any other
  assign cnt_e = state == WR_IDLE ? 3'd0 : dl_cnt;
  assign len_e = state == WR_IDLE ? 16'd0 : len;
  assign err_e = state != WR_IDLE && err;
  assign full = (wr_ptr - rd_ptr) == DEPTH;
  assign dl_full = cnt_e == 3'(FCS_BYTES);
  assign over = dl_full && (full || len_e + 16'd1 > 16'(MAX_LEN));
  assign bad = err_e || s_axis.tuser;
  assign runt = !dl_full || len_e + 16'd1 < 16'(MIN_LEN);
  always_comb begin
    state_n = state;
    wr_ptr_n = wr_ptr;
    wr_commit_n = wr_commit;
    dl_n = dl;
    dl_cnt_n = dl_cnt;
    len_n = len;
    err_n = err;
    we = 1'b0;
    wlast = 1'b0;
    drop_n = 1'b0;
    frame_n = 1'b0;
    if (beat) begin
      if (state == WR_DISCARD) begin
        if (s_axis.tlast) begin
          drop_n = 1'b1;
          state_n = WR_IDLE;
        end
      end else if (!s_axis.tlast) begin
        dl_n = {dl[FCS_BYTES-2:0], s_axis.tdata};
        dl_cnt_n = dl_full ? cnt_e : cnt_e + 3'd1;
        err_n = bad;
        len_n = len_e;
        state_n = WR_ACTIVE;
        if (over) begin
          wr_ptr_n = wr_commit;
          state_n = WR_DISCARD;
        end else if (dl_full) begin
          we = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          len_n = len_e + 16'd1;
        end
      end else begin
        state_n = WR_IDLE;
        if (!bad && !runt && !over) begin
          we = 1'b1;
          wlast = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          wr_commit_n = wr_ptr + 1'b1;
          frame_n = 1'b1;
        end else begin
          wr_ptr_n = wr_commit;
          drop_n = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WR_IDLE;
      wr_ptr <= '0;
      wr_commit <= '0;
      dl <= '0;
      dl_cnt <= '0;
      len <= '0;
      err <= 1'b0;
      sync <= 1'b0;
      drop_pulse <= 1'b0;
      frame_pulse <= 1'b0;
    end else begin
      state <= state_n;
      wr_ptr <= wr_ptr_n;
      wr_commit <= wr_commit_n;
      dl <= dl_n;
      dl_cnt <= dl_cnt_n;
      len <= len_n;
      err <= err_n;
      sync <= sync || (s_axis.tvalid && s_axis.tlast);
      drop_pulse <= drop_n;
      frame_pulse <= frame_n;
    end
  end
  eth_rx_frame_ram #(.ADDR_WIDTH(ADDR_WIDTH), .WIDTH(9)) u_ram (
    .clk(clk),
    .we(we),
    .waddr(wr_ptr[ADDR_WIDTH-1:0]),
    .wdata({wlast, dl[FCS_BYTES-1]}),
    .re(re),
    .raddr(rd_ptr[ADDR_WIDTH-1:0]),
    .rdata(rdata)
  );
  // two-stage read: RAM output (v1) prefetches into the output register
  assign empty = rd_ptr == wr_commit;
  assign load_out = !m_axis.tvalid || m_axis.tready;
  assign re = !empty && (!v1 || load_out);
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      v1 <= 1'b0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast <= 1'b0;
      m_axis.tdata <= '0;
    end else begin
      if (re) rd_ptr <= rd_ptr + 1'b1;
      v1 <= re || (v1 && !load_out);
      if (load_out) m_axis.tvalid <= v1;
      if (load_out && v1) {m_axis.tlast, m_axis.tdata} <= rdata;
    end
  end
`ifdef ETH_RX_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_good <= '0;
      stat_bad_fcs <= '0;
      stat_runt <= '0;
      stat_overflow <= '0;
    end else begin
      if (frame_n && stat_good != '1) stat_good <= stat_good + 32'd1;
      if (drop_n && (state == WR_DISCARD || over) && stat_overflow != '1) stat_overflow <= stat_overflow + 32'd1;
      if (drop_n && state != WR_DISCARD && !over && bad && stat_bad_fcs != '1) stat_bad_fcs <= stat_bad_fcs + 32'd1;
      if (drop_n && state != WR_DISCARD && !over && !bad && stat_runt != '1) stat_runt <= stat_runt + 32'd1;
    end
  end
`endif
endmodule

// File: doc/eth_rx_frame_fifo.md
Name: eth_rx_frame_fifo

Overview:
- Store-and-forward frame FIFO directly downstream of the GMII/MII frame receiver.
- Input is the receiver's AXI-stream output, which has no tready. Every frame carries its 4 FCS bytes, with tlast on the final FCS byte. tuser may be asserted on any beat, including non-last beats.
- The block strips the FCS, drops bad, runt, oversize and overflowing frames, and presents only good frames on a back-pressurable AXI-stream master for the packet-processing logic.

Parameters:
ADDR_WIDTH, 11, log2 of frame RAM depth in bytes (2048).
MIN_LEN, 60, minimum payload bytes (FCS excluded); shorter frames are dropped.
MAX_LEN, 1514, maximum payload bytes (FCS excluded); longer frames are dropped.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_axis_tdata  in  8  received byte (payload followed by FCS)
s_axis_tvalid  in  1  byte valid; may be non-contiguous (MII mode: at most every other cycle)
s_axis_tlast  in  1  last byte of frame (last FCS byte, or error-abort beat)
s_axis_tuser  in  1  frame bad; asserted on any beat of the frame
m_axis_tdata  out  8  payload byte
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last payload byte
drop_pulse  out  1  one-cycle pulse for each dropped frame
frame_pulse  out  1  one-cycle pulse for each committed frame

Behaviour:
- Reset: all pointers 0; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, drop_pulse=0, frame_pulse=0; sync=0; FCS delay line empty.
- RAM: 2^ADDR_WIDTH x 9 bits ({last, data}). Write-side pointers are wr_ptr (speculative) and wr_commit. Read-side pointer is rd_ptr.
- Pointer widths and full/empty:
  - Pointers are ADDR_WIDTH+1 bits.
  - full when (wr_ptr - rd_ptr) == 2^ADDR_WIDTH.
  - empty when rd_ptr == wr_commit.
  - Arithmetic is modulo 2^(ADDR_WIDTH+1).
- Input sync: after reset, discard beats until the first tlast beat (inclusive), then set sync=1. This prevents a partial frame after a mid-frame reset.
- Write FSM states: IDLE, ACTIVE, DISCARD.
  - IDLE: first valid beat moves to ACTIVE. Per-frame state cleared: len=0, err=0, delay line empty.
  - ACTIVE, each non-last valid beat:
    - byte shifts into the 4-deep delay line; err |= tuser.
    - If the delay line was already full, the oldest byte is written at wr_ptr with last=0; wr_ptr++; len++.
    - If the RAM is full at that write, or len would exceed MAX_LEN: wr_ptr <= wr_commit, go to DISCARD.
  - ACTIVE, tlast beat:
    - Good if err|tuser == 0, delay line full, and len+1 >= MIN_LEN.
    - If good and not full: write the oldest delay-line byte (last payload byte) with last=1; wr_commit <= wr_ptr+1; wr_ptr++; frame_pulse=1.
    - Otherwise: wr_ptr <= wr_commit; drop_pulse=1.
    - Either way, go to IDLE.
  - DISCARD: ignore beats. On tlast: drop_pulse=1, go to IDLE.
- Error-abort frames (tlast+tuser with no FCS beats following) are dropped via the err rule.
- Read side:
  - 1-cycle registered RAM read into the output register. Standard AXIS: data held stable while tvalid && !tready.
  - Prefetch keeps m_axis_tvalid continuous at one byte per cycle while frames are committed.
  - Output becomes visible 2 cycles after wr_commit updates.
- Simultaneous read and commit in the same cycle are both honoured. The full check uses the current rd_ptr; freed space is visible next cycle.
- Output never shows an uncommitted byte. tlast always ends a committed frame.

Optional Feature:
- Macro ETH_RX_FIFO_STATS_EN.
- Defined: adds outputs stat_good[31:0], stat_bad_fcs[31:0] (err set), stat_runt[31:0], stat_overflow[31:0] (RAM full or MAX_LEN).
  - Saturating counters, cleared by rst.
  - Each drop increments exactly one counter, with priority overflow > bad > runt.
- Undefined: ports and counters are absent; drop_pulse/frame_pulse are unchanged.

Decomposition:
- Package eth_pkg: write-state encoding, FCS_BYTES=4, ETH_MIN_PAYLOAD=60, ETH_MAX_PAYLOAD=1514.
- Sub-module eth_rx_frame_ram: simple dual-port RAM, 9-bit wide, registered read, inferable.

Test Plan:
1. Good 64-byte payload + 4 FCS bytes, tuser=0, tready=1 -> exactly 64 bytes out, tlast on byte 64, frame_pulse once, FCS bytes absent.
2. Same frame with tuser=1 on the 10th beat -> no output; drop_pulse once; next good frame passes intact.
3. Frames of 59-byte and 60-byte payload -> first dropped, second output with 60 bytes.
4. ADDR_WIDTH=7, tready=0, three 60-byte frames -> frames 1-2 committed, frame 3 dropped (overflow). Then tready=1 -> 120 bytes out in order.
5. MII pacing (tvalid every other cycle) with tready toggling at random -> output byte-exact, no duplicates or losses.
6. rst asserted mid-frame, input resumes mid-frame -> remainder discarded until tlast; next frame output correctly.
